// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer: access-size encoding,
// the per-entry record, and the byte-enable generator.
package sb_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } sb_size_t;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [5:0]  rob;
    } sb_entry_t;

    // Byte enables for an access of the given size at byte offset off.
    // The reserved size encoding is treated as a full word.
    function automatic logic [3:0] sb_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << (off & 2'b10);
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Handshake and bus bundle between the LSU/commit logic, the store buffer
// and the data-memory write port. The master side drives requests, the
// slave side (the store buffer) drives status and the bus write.
interface store_buffer_if;
    logic        flush_i;
    logic        st_vld_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic [1:0]  st_size_i;
    logic [5:0]  st_rob_i;
    logic [1:0]  commit_cnt_i;
    logic        ld_vld_i;
    logic [31:0] ld_addr_i;
    logic [1:0]  ld_size_i;
    logic        ld_conflict_o;
    logic        full_o;
    logic        store_buffer_empty_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;

    modport master (
        output flush_i, st_vld_i, st_addr_i, st_data_i, st_size_i, st_rob_i,
               commit_cnt_i, ld_vld_i, ld_addr_i, ld_size_i, bus_ack_i,
        input  ld_conflict_o, full_o, store_buffer_empty_o,
               bus_req_o, bus_addr_o, bus_wdata_o, bus_be_o
    );

    modport slave (
        input  flush_i, st_vld_i, st_addr_i, st_data_i, st_size_i, st_rob_i,
               commit_cnt_i, ld_vld_i, ld_addr_i, ld_size_i, bus_ack_i,
        output ld_conflict_o, full_o, store_buffer_empty_o,
               bus_req_o, bus_addr_o, bus_wdata_o, bus_be_o
    );
endinterface

// File: rtl/sb_lane_align.sv
// Combinational lane aligner: turns size + byte offset + LSB-justified data
// into byte enables and data replicated across the 32-bit bus lanes.
module sb_lane_align
    import sb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] lanes
);

    assign be = sb_be(size, offset);

    // Replicate the payload so every enabled lane carries the right bytes.
    always_comb begin
        case (size)
            SZ_B:    lanes = {4{data[7:0]}};
            SZ_H:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer. Three wrap-bit pointers split the ring into a
// committed region (head..commit, drained to the bus) and a speculative
// region (commit..tail, discarded on flush). Also provides the empty fence
// status and a combinational load-overlap flag.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic     cpu_clk_i,
    input  logic     cpu_rst_ni,
    store_buffer_if.slave sb
);

    logic [PW:0] head, commit, tail;
    logic [PW:0] count, commit_nxt, tail_nxt;
    logic        full, enq, pop, conflict_any;
    logic [3:0]  st_be, ld_be;
    logic [31:0] st_lanes, ld_lanes_unused;
    logic [PW-1:0] slot_off;
    logic        unused_rob;
    sb_entry_t   entries [DEPTH];
    sb_entry_t   head_entry;

    sb_lane_align u_st_align (
        .size   (sb.st_size_i),
        .offset (sb.st_addr_i[1:0]),
        .data   (sb.st_data_i),
        .be     (st_be),
        .lanes  (st_lanes)
    );

    // Only the byte enables of the load are needed for the overlap check.
    sb_lane_align u_ld_align (
        .size   (sb.ld_size_i),
        .offset (sb.ld_addr_i[1:0]),
        .data   (32'h0),
        .be     (ld_be),
        .lanes  (ld_lanes_unused)
    );

    assign count      = tail - head;
    assign full       = (count == (PW+1)'(DEPTH));
    assign enq        = sb.st_vld_i & ~full & ~sb.flush_i;
    assign pop        = sb.bus_req_o & sb.bus_ack_i;
    // Commit lands first, so a flush truncates to the post-commit boundary.
    assign commit_nxt = commit + (PW+1)'(sb.commit_cnt_i);
    assign tail_nxt   = sb.flush_i ? commit_nxt : tail + {{PW{1'b0}}, enq};

    // Pointer state: the only control that needs reset.
    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            head   <= '0;
            commit <= '0;
            tail   <= '0;
        end else begin
            head   <= head + {{PW{1'b0}}, pop};
            commit <= commit_nxt;
            tail   <= tail_nxt;
        end
    end

    // Entry storage: validity comes from the pointers, so no reset here.
    always_ff @(posedge cpu_clk_i) begin
        if (enq) begin
            entries[tail[PW-1:0]] <= '{waddr: sb.st_addr_i[31:2],
                                       be:    st_be,
                                       data:  st_lanes,
                                       rob:   sb.st_rob_i};
        end
    end

    assign head_entry = entries[head[PW-1:0]];
    assign unused_rob = ^head_entry.rob;

    assign sb.bus_req_o            = (head != commit);
    assign sb.bus_addr_o           = {head_entry.waddr, 2'b00};
    assign sb.bus_be_o             = head_entry.be;
    assign sb.bus_wdata_o          = head_entry.data;
    assign sb.full_o               = full;
    assign sb.store_buffer_empty_o = (head == tail);

    // Overlap scan over every occupied slot, committed or speculative;
    // a slot is occupied when its distance from head is below count.
    always_comb begin
        conflict_any = 1'b0;
        slot_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - head[PW-1:0];
            if (({1'b0, slot_off} < count) &&
                (entries[i].waddr == sb.ld_addr_i[31:2]) &&
                ((entries[i].be & ld_be) != 4'h0)) begin
                conflict_any = 1'b1;
            end
        end
    end

    assign sb.ld_conflict_o = sb.ld_vld_i & conflict_any;

    commit_within_tail: assert property (
        @(posedge cpu_clk_i) disable iff (!cpu_rst_ni)
        ((PW+1)'(sb.commit_cnt_i) <= (tail - commit))
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a drain scoreboard.
module tb_store_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   failed   = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    store_buffer_if sb ();

    store_buffer #(.DEPTH(8), .PW(3)) dut (
        .cpu_clk_i  (clk),
        .cpu_rst_ni (rst_n),
        .sb         (sb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic put_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        sb.st_vld_i  = 1'b1;
        sb.st_addr_i = a;
        sb.st_data_i = d;
        sb.st_size_i = s;
        sb.st_rob_i  = a[7:2];
    endtask

    task automatic probe(input logic [31:0] a, input logic [1:0] s);
        sb.ld_vld_i  = 1'b1;
        sb.ld_addr_i = a;
        sb.ld_size_i = s;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.be   = be;
        e.data = d;
        sbq.push_back(e);
    endtask

    // Drain monitor: every accepted bus write must match the oldest expected store.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.st_vld_i && sb.full_o) begin
                failed++;
                $display("FAIL enq_while_full: st_vld_i=1 with full_o=1");
            end
            if (sb.bus_req_o && sbq.size() == 0) begin
                failed++;
                $display("FAIL unexpected_bus_req: addr 0x%08h presented, none expected", sb.bus_addr_o);
            end else if (sb.bus_req_o && sb.bus_ack_i) begin : pop_blk
                exp_t e;
                e = sbq.pop_front();
                chk("drain_addr",  sb.bus_addr_o,  e.addr);
                chk("drain_be",    {28'h0, sb.bus_be_o}, {28'h0, e.be});
                chk("drain_wdata", sb.bus_wdata_o, e.data);
            end
        end
    end

    initial begin
        sb.flush_i      = 1'b0;
        sb.st_vld_i     = 1'b0;
        sb.st_addr_i    = '0;
        sb.st_data_i    = '0;
        sb.st_size_i    = '0;
        sb.st_rob_i     = '0;
        sb.commit_cnt_i = '0;
        sb.ld_vld_i     = 1'b0;
        sb.ld_addr_i    = '0;
        sb.ld_size_i    = '0;
        sb.bus_ack_i    = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        at_neg();
        chk("rst_bus_req",  sb.bus_req_o, 0);
        chk("rst_full",     sb.full_o, 0);
        chk("rst_empty",    sb.store_buffer_empty_o, 1);
        chk("rst_conflict", sb.ld_conflict_o, 0);

        // Byte store at 0x1003, committed, drained
        tick();
        put_st(32'h1003, 32'h0000_00AB, 2'd0);
        tick();
        sb.st_vld_i     = 1'b0;
        sb.commit_cnt_i = 2'd1;
        push_exp(32'h1000, 4'b1000, 32'hABAB_ABAB);
        tick();
        sb.commit_cnt_i = 2'd0;
        at_neg();
        chk("t1_req",   sb.bus_req_o, 1);
        chk("t1_addr",  sb.bus_addr_o, 32'h1000);
        chk("t1_be",    {28'h0, sb.bus_be_o}, 32'h8);
        chk("t1_wdata", sb.bus_wdata_o, 32'hABAB_ABAB);
        chk("t1_empty", sb.store_buffer_empty_o, 0);
        tick();
        sb.bus_ack_i = 1'b1;
        tick();
        sb.bus_ack_i = 1'b0;
        at_neg();
        chk("t1_req_done", sb.bus_req_o, 0);
        chk("t1_empty_done", sb.store_buffer_empty_o, 1);

        // Fill with 8 speculative stores, then flush them all
        tick();
        for (int i = 0; i < 7; i++) begin
            put_st(32'h8000 + 32'h100 * i, i, 2'd2);
            tick();
        end
        sb.st_vld_i = 1'b0;
        at_neg();
        chk("t2_full_at7", sb.full_o, 0);
        tick();
        put_st(32'h8700, 32'h7, 2'd2);
        tick();
        sb.st_vld_i = 1'b0;
        at_neg();
        chk("t2_full_at8", sb.full_o, 1);
        chk("t2_empty",    sb.store_buffer_empty_o, 0);
        chk("t2_req",      sb.bus_req_o, 0);
        tick();
        sb.flush_i = 1'b1;
        tick();
        sb.flush_i = 1'b0;
        at_neg();
        chk("t2_empty_after_flush", sb.store_buffer_empty_o, 1);
        chk("t2_full_after_flush",  sb.full_o, 0);
        chk("t2_req_after_flush",   sb.bus_req_o, 0);

        // Three stores, commit two with a flush in the same cycle
        tick();
        put_st(32'h3000, 32'h1122_3344, 2'd2);
        tick();
        put_st(32'h3006, 32'h0000_BEEF, 2'd1);
        tick();
        put_st(32'h3009, 32'h0000_005A, 2'd0);
        tick();
        put_st(32'h3010, 32'hDEAD_DEAD, 2'd2);
        sb.flush_i      = 1'b1;
        sb.commit_cnt_i = 2'd2;
        push_exp(32'h3000, 4'b1111, 32'h1122_3344);
        push_exp(32'h3004, 4'b1100, 32'hBEEF_BEEF);
        tick();
        sb.st_vld_i     = 1'b0;
        sb.flush_i      = 1'b0;
        sb.commit_cnt_i = 2'd0;
        at_neg();
        chk("t3_req",  sb.bus_req_o, 1);
        chk("t3_addr", sb.bus_addr_o, 32'h3000);
        tick();
        sb.bus_ack_i = 1'b1;
        tick();
        tick();
        sb.bus_ack_i = 1'b0;
        at_neg();
        chk("t3_req_done", sb.bus_req_o, 0);
        chk("t3_empty",    sb.store_buffer_empty_o, 1);

        // Load conflict probes against a speculative half store at 0x2002
        tick();
        put_st(32'h2002, 32'h0000_1234, 2'd1);
        tick();
        sb.st_vld_i = 1'b0;
        probe(32'h2000, 2'd1);
        at_neg();
        chk("t4_half_lo", sb.ld_conflict_o, 0);
        tick();
        probe(32'h2003, 2'd0);
        at_neg();
        chk("t4_byte3", sb.ld_conflict_o, 1);
        tick();
        probe(32'h2004, 2'd2);
        at_neg();
        chk("t4_other_word", sb.ld_conflict_o, 0);
        tick();
        probe(32'h2002, 2'd1);
        sb.ld_vld_i = 1'b0;
        at_neg();
        chk("t4_no_ld_vld", sb.ld_conflict_o, 0);
        tick();
        put_st(32'h2040, 32'hFFFF_FFFF, 2'd2);
        probe(32'h2041, 2'd0);
        at_neg();
        chk("t4_same_cycle_enq", sb.ld_conflict_o, 0);
        tick();
        sb.st_vld_i = 1'b0;
        at_neg();
        chk("t4_next_cycle_enq", sb.ld_conflict_o, 1);
        tick();
        sb.ld_vld_i = 1'b0;
        sb.flush_i  = 1'b1;
        tick();
        sb.flush_i = 1'b0;
        probe(32'h2003, 2'd0);
        at_neg();
        chk("t4_after_flush", sb.ld_conflict_o, 0);
        chk("t4_empty",       sb.store_buffer_empty_o, 1);
        tick();
        sb.ld_vld_i = 1'b0;

        // Ack stall: head entry must hold steady, then advance by one
        put_st(32'h4000, 32'hCAFE_F00D, 2'd2);
        tick();
        put_st(32'h4011, 32'h0000_0077, 2'd0);
        tick();
        sb.st_vld_i     = 1'b0;
        sb.commit_cnt_i = 2'd2;
        push_exp(32'h4000, 4'b1111, 32'hCAFE_F00D);
        push_exp(32'h4010, 4'b0010, 32'h7777_7777);
        tick();
        sb.commit_cnt_i = 2'd0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("t5_stall_addr",  sb.bus_addr_o, 32'h4000);
            chk("t5_stall_be",    {28'h0, sb.bus_be_o}, 32'hF);
            chk("t5_stall_wdata", sb.bus_wdata_o, 32'hCAFE_F00D);
            tick();
        end
        sb.bus_ack_i = 1'b1;
        tick();
        sb.bus_ack_i = 1'b0;
        at_neg();
        chk("t5_next_req",   sb.bus_req_o, 1);
        chk("t5_next_addr",  sb.bus_addr_o, 32'h4010);
        chk("t5_next_be",    {28'h0, sb.bus_be_o}, 32'h2);
        chk("t5_next_wdata", sb.bus_wdata_o, 32'h7777_7777);
        tick();
        sb.bus_ack_i = 1'b1;
        tick();
        sb.bus_ack_i = 1'b0;
        at_neg();
        chk("t5_empty", sb.store_buffer_empty_o, 1);

        // Asynchronous reset with four committed entries still held
        tick();
        for (int i = 0; i < 5; i++) begin
            put_st(32'h6000 + 32'h4 * i, 32'h60 + i, 2'd2);
            push_exp(32'h6000 + 32'h4 * i, 4'b1111, 32'h60 + i);
            tick();
        end
        sb.st_vld_i     = 1'b0;
        sb.commit_cnt_i = 2'd2;
        tick();
        tick();
        sb.commit_cnt_i = 2'd1;
        tick();
        sb.commit_cnt_i = 2'd0;
        sb.bus_ack_i    = 1'b1;
        tick();
        sb.bus_ack_i = 1'b0;
        probe(32'h6004, 2'd2);
        at_neg();
        chk("t6_conflict_pre", sb.ld_conflict_o, 1);
        chk("t6_req_pre",      sb.bus_req_o, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_req",      sb.bus_req_o, 0);
        chk("t6_rst_full",     sb.full_o, 0);
        chk("t6_rst_empty",    sb.store_buffer_empty_o, 1);
        chk("t6_rst_conflict", sb.ld_conflict_o, 0);
        sbq.delete();
        sb.ld_vld_i  = 1'b0;
        sb.bus_ack_i = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            chk("t6_req_after_release", sb.bus_req_o, 0);
            tick();
        end
        sb.bus_ack_i = 1'b0;

        // Normal operation resumes after reset
        put_st(32'h5000, 32'h0BAD_F00D, 2'd2);
        tick();
        sb.st_vld_i     = 1'b0;
        sb.commit_cnt_i = 2'd1;
        push_exp(32'h5000, 4'b1111, 32'h0BAD_F00D);
        tick();
        sb.commit_cnt_i = 2'd0;
        sb.bus_ack_i    = 1'b1;
        tick();
        sb.bus_ack_i = 1'b0;
        at_neg();
        chk("t7_empty", sb.store_buffer_empty_o, 1);

        chk("scoreboard_left", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Holds stores issued by the memory scheduler's LSU path from issue until ROB commit, then drains them in order to the data-memory write port.
- Supplies the `store_buffer_empty` status that fences and system instructions wait on.
- Supplies a load-conflict flag so younger loads stall rather than read stale memory.
- Sits between LSU issue (downstream of the memory scheduler) and the data bus.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PW, 3, log2(DEPTH); pointers are PW+1 bits (extra wrap bit).

Ports:
- cpu_clk_i  in  1  core clock
- cpu_rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; discards uncommitted entries
- st_vld_i  in  1  store enqueue strobe
- st_addr_i  in  32  byte address (alignment already checked upstream)
- st_data_i  in  32  store data, LSB-justified
- st_size_i  in  2  0=byte, 1=half, 2=word (3 reserved)
- st_rob_i  in  6  ROB tag of the store
- commit_cnt_i  in  2  stores committed this cycle, 0..2, oldest first
- ld_vld_i  in  1  load probe valid
- ld_addr_i  in  32  load byte address
- ld_size_i  in  2  load size, same encoding as st_size_i
- ld_conflict_o  out  1  a buffered store overlaps the probed load bytes
- full_o  out  1  count==DEPTH
- store_buffer_empty_o  out  1  no entries, committed or speculative
- bus_req_o  out  1  committed head entry presented for write
- bus_addr_o  out  32  head address, bits[1:0]=0
- bus_wdata_o  out  32  lane-replicated data
- bus_be_o  out  4  byte enables
- bus_ack_i  in  1  write accepted this cycle

Behaviour:
- Reset (async, cpu_rst_ni=0): head, commit and tail pointers = 0; all entries invalid.
  - Outputs at reset: bus_req_o=0, full_o=0, store_buffer_empty_o=1, ld_conflict_o=0.
- Three pointers bound two regions:
  - head..commit = committed, drainable.
  - commit..tail = speculative.
  - Invariant: head <= commit <= tail (modulo wrap); count = tail-head.
- Enqueue:
  - When st_vld_i & !full_o & !flush_i, write the entry at tail; tail+1 at the clock edge.
  - The entry stores: word address, be, replicated data, rob.
  - A st_vld_i that arrives while full_o is high, or while flush_i is high, is dropped. Upstream guarantees the full case cannot occur via lsu_busy; the bench asserts it never does.
- Byte-enable encoding:
  - byte: be = 1<<addr[1:0].
  - half: be = 4'b0011<<{addr[1],1'b0}.
  - word: be = 4'hF.
  - st_size_i=3 is treated as word.
- Data replication:
  - byte: {4{d[7:0]}}.
  - half: {2{d[15:0]}}.
  - word: d.
- Commit:
  - commit <= commit + commit_cnt_i.
  - commit_cnt_i > (tail-commit) is illegal and must be asserted against.
  - Commit is applied in the same cycle as a flush, before the flush truncation.
- Flush:
  - tail <= commit-after-this-cycle's-commit_cnt_i; speculative entries are discarded.
  - Committed entries survive and keep draining.
  - Enqueue is suppressed in the flush cycle.
- Drain:
  - bus_req_o = (head != commit), combinational from registered pointers.
  - bus_addr_o, bus_be_o and bus_wdata_o are taken from the head entry and remain stable while bus_req_o=1 and no ack has occurred.
  - On bus_req_o & bus_ack_i, head+1 at the edge. Back-to-back drain is allowed: next entry presented the following cycle with no bubble.
  - bus_ack_i while bus_req_o=0 is ignored.
- Simultaneous events:
  - Enqueue, commit, drain and flush may all occur in one cycle.
  - Count updates as +enq − pop.
  - full_o and store_buffer_empty_o are derived from the registered pointers (one-cycle latency).
- Load conflict (combinational):
  - ld_conflict_o = ld_vld_i & OR over all valid entries of (entry word addr == ld_addr_i[31:2] & (entry be & ld_be) != 0).
  - Both committed and speculative entries count.
  - Entries enqueued this cycle are not checked; they are checked from the next cycle.
- Wrap-around: pointers wrap modulo 2*DEPTH.
  - full when MSBs differ and the low bits are equal.
  - empty when the pointers are equal.

Decomposition:
- Package `sb_pkg`:
  - `sb_size_t` enum (SZ_B, SZ_H, SZ_W).
  - `sb_entry_t` struct {waddr[29:0], be[3:0], data[31:0], rob[5:0]}.
  - Function computing be from size/offset.
- One sub-module, `sb_lane_align`, combinational: size+addr+data -> be + replicated data. It is instantiated twice: on the enqueue path, and for the load be (data unused).

Test Plan:
- Reset, then enqueue a byte store at addr 0x1003 with data 0xAB, commit 1 → next cycle bus_req_o=1, bus_addr_o=0x1000, bus_be_o=4'b1000, bus_wdata_o=0xABABABAB.
- Enqueue 8 stores without commit → full_o=1 the following cycle; flush_i → tail=commit, store_buffer_empty_o=1 the next cycle, bus_req_o never asserted.
- Enqueue 3 stores, commit_cnt_i=2, flush in the same cycle → 2 entries drain with bus_ack_i held high on consecutive cycles, third never appears, then empty_o=1.
- Half store to 0x2002, then a load probe at 0x2000 half → ld_conflict_o=0; probe at 0x2003 byte → ld_conflict_o=1.
- Stall bus_ack_i low for 5 cycles → bus_addr_o, bus_be_o and bus_wdata_o are constant throughout; ack → head advances by exactly 1.
- Assert cpu_rst_ni low mid-drain with 4 entries held → all outputs take their reset values immediately (asynchronously), with no bus_req_o after release.
